dot_feeder: RTL and testbench

DOT_FEEDER -- requirements
Module: dot_feeder

---
 rtl/dot_feeder_pkg.sv | 8 +
 rtl/dot_feeder_if.sv | 31 +++
 rtl/dot_feeder_ram.sv | 19 +
 rtl/dot_feeder.sv | 109 ++++++++++
 tb/tb_dot_feeder.sv | 134 +++++++++++++
 5 files changed

// File: rtl/dot_feeder_pkg.sv
// dot_feeder_pkg: shared FSM state type and default widths for the dot-product operand feeder
package dot_feeder_pkg;
  localparam int IW_D = 8;
  localparam int WW_D = 11;
  localparam int DATAW_D = IW_D + WW_D;
  localparam int DEPTH_D = 64;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
endpackage

// File: rtl/dot_feeder_if.sv
// dot_feeder_if: write port, frame request and product stream of the dot feeder
interface dot_feeder_if
  import dot_feeder_pkg::*;
#(
  parameter int IW = IW_D,
  parameter int WW = WW_D,
  parameter int DATAW = DATAW_D,
  parameter int ADDRW = $clog2(DEPTH_D)
);
  logic x_we;
  logic w_we;
  logic [ADDRW-1:0] waddr;
  logic signed [IW-1:0] x_wdata;
  logic signed [WW-1:0] w_wdata;
  logic start;
  logic [ADDRW:0] len;
  logic signed [DATAW-1:0] data;
  logic ovalid;
  logic first;
  logic last;
  logic busy;
  logic done;
  modport master (
    output x_we, w_we, waddr, x_wdata, w_wdata, start, len,
    input data, ovalid, first, last, busy, done
  );
  modport slave (
    input x_we, w_we, waddr, x_wdata, w_wdata, start, len,
    output data, ovalid, first, last, busy, done
  );
endinterface

// File: rtl/dot_feeder_ram.sv
// dot_feeder_ram: single-write single-read synchronous RAM with one-cycle read latency
module dot_feeder_ram #(
  parameter int W = 8,
  parameter int DEPTH = 64,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [ADDRW-1:0] waddr,
  input logic [W-1:0] wdata,
  input logic [ADDRW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/dot_feeder.sv
// dot_feeder: streams x[k]*w[k] for k=0..len-1 from two operand RAMs with first/last/done framing
module dot_feeder
  import dot_feeder_pkg::*;
#(
  parameter int IW = IW_D,
  parameter int WW = WW_D,
  parameter int DATAW = DATAW_D,
  parameter int DEPTH = DEPTH_D
) (
  input logic clk,
  input logic rst,
  dot_feeder_if.slave bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam logic [ADDRW:0] DEPTH_L = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0] ONE = (ADDRW+1)'(1);
  state_t r_state;
  logic [ADDRW-1:0] r_addr;
  logic [ADDRW-1:0] r_last_addr;
  logic r_v1;
  logic r_f1;
  logic r_l1;
  logic signed [DATAW-1:0] r_data;
  logic r_ovalid;
  logic r_first;
  logic r_last;
  logic r_busy;
  logic r_done;
  logic signed [IW-1:0] w_x;
  logic signed [WW-1:0] w_w;
  logic signed [DATAW-1:0] w_prod;
  logic w_len_ok;
  dot_feeder_ram #(.W(IW), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_x_ram (
    .clk(clk),
    .we(bus.x_we & ~r_busy),
    .waddr(bus.waddr),
    .wdata(bus.x_wdata),
    .raddr(r_addr),
    .rdata(w_x)
  );
  dot_feeder_ram #(.W(WW), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_w_ram (
    .clk(clk),
    .we(bus.w_we & ~r_busy),
    .waddr(bus.waddr),
    .wdata(bus.w_wdata),
    .raddr(r_addr),
    .rdata(w_w)
  );
  assign w_prod = w_x * w_w;
  assign w_len_ok = (bus.len != '0) && (bus.len <= DEPTH_L);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_last_addr <= '0;
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
      r_l1 <= 1'b0;
      r_data <= '0;
      r_ovalid <= 1'b0;
      r_first <= 1'b0;
      r_last <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      r_done <= 1'b0;
      r_ovalid <= r_v1;
      r_data <= r_v1 ? w_prod : '0;
      r_first <= r_v1 & r_f1;
      r_last <= r_v1 & r_l1;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start && !r_busy) begin
            if (w_len_ok) begin
              r_state <= S_RUN;
              r_addr <= '0;
              r_last_addr <= ADDRW'(bus.len - ONE);
              r_busy <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_v1 <= 1'b1;
          r_f1 <= r_addr == '0;
          r_l1 <= r_addr == r_last_addr;
          if (r_addr == r_last_addr) r_state <= S_DRAIN;
          else r_addr <= r_addr + 1'b1;
        end
        S_DRAIN: begin
          if (r_ovalid && r_last) begin
            r_done <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.data = r_data;
  assign bus.ovalid = r_ovalid;
  assign bus.first = r_first;
  assign bus.last = r_last;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_dot_feeder.sv
// tb_dot_feeder: randomized frames checked against an array model of the operand memories
module tb_dot_feeder;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  int mx [64];
  int mw [64];
  dot_feeder_if #(.IW(8), .WW(11), .DATAW(19), .ADDRW(6)) bus ();
  dot_feeder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input int x, input int w, input bit xe, input bit we);
    bus.x_we = xe;
    bus.w_we = we;
    bus.waddr = 6'(a);
    bus.x_wdata = 8'(x);
    bus.w_wdata = 11'(w);
    tick();
    bus.x_we = 1'b0;
    bus.w_we = 1'b0;
    if (xe) mx[a] = x;
    if (we) mw[a] = w;
  endtask
  task automatic rnd_fill(input int lo, input int hi);
    for (int a = lo; a <= hi; a++)
      wr(a, int'($urandom_range(255)) - 128, int'($urandom_range(2047)) - 1024, 1'b1, 1'b1);
  endtask
  // beat k is expected 2+k cycles after the start edge; done and busy follow from len alone
  task automatic frame(input int n, input int inj, input int rst_at);
    int beats = 0;
    int done_cnt = 0;
    int done_c = -1;
    int busy_cnt = 0;
    bit ok = (n >= 1) && (n <= 64);
    bus.start = 1'b1;
    bus.len = 7'(n);
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < n + 8; c++) begin
      if (rst_at >= 0 && c == rst_at + 1)
        check("rst_out", {bus.data, bus.ovalid, bus.first, bus.last, bus.busy, bus.done}, 0);
      if (bus.ovalid) begin
        if (beats < n) check("data", $signed(bus.data), longint'(mx[beats]) * mw[beats]);
        check("first", bus.first, beats == 0);
        check("last", bus.last, beats == n - 1);
        check("beat_cycle", c, 2 + beats);
        beats++;
      end else begin
        check("hold0", {bus.first, bus.last, bus.data}, 0);
      end
      if (bus.done) begin
        done_cnt++;
        done_c = c;
      end
      if (bus.busy) busy_cnt++;
      bus.start = (c == inj);
      bus.len = (c == inj) ? 7'd3 : 7'(n);
      bus.x_we = (c == inj);
      bus.waddr = '0;
      bus.x_wdata = 8'sd55;
      rst = (c == rst_at);
      tick();
    end
    bus.start = 1'b0;
    bus.x_we = 1'b0;
    rst = 1'b0;
    if (rst_at >= 0) begin
      check("abort_beats", beats, rst_at - 1);
      check("abort_done", done_cnt, 0);
    end else begin
      check("beats", beats, ok ? n : 0);
      check("done_cnt", done_cnt, 1);
      check("done_cycle", done_c, ok ? 2 + n : 0);
      check("busy_cycles", busy_cnt, ok ? n + 3 : 0);
    end
  endtask
  initial begin
    bus.x_we = 1'b0;
    bus.w_we = 1'b0;
    bus.waddr = '0;
    bus.x_wdata = '0;
    bus.w_wdata = '0;
    bus.start = 1'b0;
    bus.len = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_ovalid", bus.ovalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_data", $signed(bus.data), 0);
    check("rst_fl", {bus.first, bus.last}, 0);
    rst = 1'b0;
    rnd_fill(0, 63);
    wr(0, 1, 5, 1'b1, 1'b1);
    wr(1, -2, 7, 1'b1, 1'b1);
    wr(2, 3, -1, 1'b1, 1'b1);
    wr(3, 127, -1024, 1'b1, 1'b1);
    frame(4, -1, -1);
    wr(0, -128, -1024, 1'b1, 1'b1);
    frame(1, -1, -1);
    frame(0, -1, -1);
    frame(65, -1, -1);
    frame(127, -1, -1);
    rnd_fill(0, 3);
    frame(4, 1, -1);
    frame(4, -1, -1);
    rnd_fill(0, 7);
    frame(8, -1, 3);
    frame(8, -1, -1);
    wr(5, -77, 999, 1'b1, 1'b0);
    wr(4, 0, 1000, 1'b0, 1'b1);
    frame(6, -1, -1);
    for (int i = 0; i < 6; i++) begin
      rnd_fill(int'($urandom_range(63)), 63);
      frame(int'($urandom_range(1, 64)), -1, -1);
    end
    rnd_fill(0, 63);
    frame(64, -1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
